// File: rtl/dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, byte-width codes,
// the latched transaction record and the alignment/range fault check.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] BW_NONE = 2'b00;
    localparam logic [1:0] BW_BYTE = 2'b01;
    localparam logic [1:0] BW_HALF = 2'b10;
    localparam logic [1:0] BW_WORD = 2'b11;

    // One accepted request, frozen in IDLE and replayed to the dm in ACCESS.
    typedef struct packed {
        logic        owner;   // 0 = MEM stage, 1 = loader/debug
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  bw;
        logic        sext;
        logic        fault;
    } xact_t;

    // Misaligned, illegal width or beyond the last dm word.
    function automatic logic access_fault(input logic [31:0] addr,
                                          input logic [1:0]  bw,
                                          input int unsigned dm_words);
        logic        align_f;
        logic [31:0] word_idx;
        case (bw)
            BW_WORD: align_f = (addr[1:0] != 2'b00);
            BW_HALF: align_f = addr[0];
            BW_BYTE: align_f = 1'b0;
            BW_NONE: align_f = 1'b1;
        endcase
        word_idx = {2'b00, addr[31:2]};
        return align_f | (word_idx >= dm_words);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response bundle between one master and the arbiter.
// Handshake: the master raises req with all fields stable and holds them
// until it sees ack for one cycle; rdata and err are valid only while ack=1.
// A req still high in the cycle after ack is taken as a fresh request.
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  bw;
    logic        sext;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output req, we, addr, wdata, bw, sext,
                    input  rdata, ack, err);
    modport slave  (input  req, we, addr, wdata, bw, sext,
                    output rdata, ack, err);
endinterface

// File: rtl/dm_arbiter_pick.sv
// Combinational winner select plus next values of the round-robin pointer
// and the starvation counter. Only consulted while the FSM is in IDLE.
module dm_arbiter_pick
    import dm_arbiter_pkg::*;
#(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             m0_req_i,
    input  logic             m1_req_i,
    input  logic             rr_last_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             grant_valid_o,
    output logic             grant_o,
    output logic             rr_last_o,
    output logic [CNT_W-1:0] starve_cnt_o
);

    // Pick a winner; fixed mode lets m1 through once m0 has won STARVE_LIMIT times in a row.
    always_comb begin
        grant_valid_o = m0_req_i | m1_req_i;
        grant_o       = 1'b0;
        rr_last_o     = rr_last_i;
        starve_cnt_o  = starve_cnt_i;
        if (ARB_MODE == 1) begin
            starve_cnt_o = '0;
            if (m0_req_i && m1_req_i) begin
                grant_o = ~rr_last_i;
            end else begin
                grant_o = m1_req_i;
            end
        end else begin
            if (m0_req_i && m1_req_i) begin
                if (starve_cnt_i == STARVE_LIMIT[CNT_W-1:0]) begin
                    grant_o      = 1'b1;
                    starve_cnt_o = '0;
                end else begin
                    grant_o      = 1'b0;
                    starve_cnt_o = starve_cnt_i + 1'b1;
                end
            end else begin
                // m1 granted alone or not waiting at all: nothing is starving
                grant_o      = m1_req_i;
                starve_cnt_o = '0;
            end
        end
        if (grant_valid_o) begin
            rr_last_o = grant_o;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of the single-port data memory. Serialises
// requests through IDLE -> ACCESS -> RESP, faults bad accesses before they
// reach the dm, and returns registered read data with a one-cycle ack.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int DM_WORDS     = 1024
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  m0,
    dm_arbiter_if.slave  m1,
    output logic         m0_stall,
    output logic [31:0]  dm_addr,
    output logic         dm_wEn,
    output logic [31:0]  dm_BusW,
    output logic [1:0]   dm_ByteWidth,
    output logic         dm_SignExt,
    input  logic [31:0]  dm_BusR,
    output state_e       state_o
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    state_e           state_q;
    xact_t            xact_q;
    xact_t            xact_d;
    logic [31:0]      rdata_q;
    logic             rr_last_q;
    logic             rr_last_d;
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             grant_valid;
    logic             grant;
    logic             in_access;
    logic             in_resp;
    logic             ack0;
    logic             ack1;

    dm_arbiter_pick #(
        .ARB_MODE     (ARB_MODE),
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .m0_req_i      (m0.req),
        .m1_req_i      (m1.req),
        .rr_last_i     (rr_last_q),
        .starve_cnt_i  (starve_cnt_q),
        .grant_valid_o (grant_valid),
        .grant_o       (grant),
        .rr_last_o     (rr_last_d),
        .starve_cnt_o  (starve_cnt_d)
    );

    // Capture the winner's fields and pre-compute its fault before latching.
    always_comb begin
        xact_d       = '0;
        xact_d.owner = grant;
        if (grant) begin
            xact_d.we    = m1.we;
            xact_d.addr  = m1.addr;
            xact_d.wdata = m1.wdata;
            xact_d.bw    = m1.bw;
            xact_d.sext  = m1.sext;
        end else begin
            xact_d.we    = m0.we;
            xact_d.addr  = m0.addr;
            xact_d.wdata = m0.wdata;
            xact_d.bw    = m0.bw;
            xact_d.sext  = m0.sext;
        end
        xact_d.fault = access_fault(xact_d.addr, xact_d.bw, DM_WORDS);
    end

    // Sequencer FSM with request latch, arbitration state and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            xact_q       <= '0;
            rdata_q      <= '0;
            rr_last_q    <= 1'b1;
            starve_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    starve_cnt_q <= starve_cnt_d;
                    if (grant_valid) begin
                        rr_last_q <= rr_last_d;
                        xact_q    <= xact_d;
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= (xact_q.we | xact_q.fault) ? 32'h0 : dm_BusR;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);
    assign state_o   = state_q;

    // Drive the dm only during ACCESS; the write strobe also drops the moment rst rises.
    always_comb begin
        dm_addr      = 32'h0;
        dm_wEn       = 1'b0;
        dm_BusW      = 32'h0;
        dm_ByteWidth = BW_NONE;
        dm_SignExt   = 1'b0;
        if (in_access) begin
            dm_addr      = xact_q.addr;
            dm_wEn       = xact_q.we & ~xact_q.fault & ~rst;
            dm_BusW      = xact_q.wdata;
            dm_ByteWidth = xact_q.fault ? BW_NONE : xact_q.bw;
            dm_SignExt   = xact_q.sext;
        end
    end

    // Response is decoded from the registered state, so a reset during RESP still acks.
    assign ack0     = in_resp & ~xact_q.owner;
    assign ack1     = in_resp &  xact_q.owner;
    assign m0.ack   = ack0;
    assign m1.ack   = ack1;
    assign m0.err   = ack0 & xact_q.fault;
    assign m1.err   = ack1 & xact_q.fault;
    assign m0.rdata = ack0 ? rdata_q : 32'h0;
    assign m1.rdata = ack1 ? rdata_q : 32'h0;
    assign m0_stall = m0.req & ~ack0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a fixed-priority instance (dut_a) and a
// round-robin instance (dut_b), each in front of a small behavioural dm.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dm_arbiter_if ia0 ();
    dm_arbiter_if ia1 ();
    dm_arbiter_if ib0 ();
    dm_arbiter_if ib1 ();

    logic [31:0] a_dm_addr, a_dm_busw, a_dm_busr;
    logic        a_dm_wen, a_dm_sext, a_stall;
    logic [1:0]  a_dm_bw;
    state_e      a_state;
    logic [31:0] b_dm_addr, b_dm_busw, b_dm_busr;
    logic        b_dm_wen, b_dm_sext, b_stall;
    logic [1:0]  b_dm_bw;
    state_e      b_state;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];

    dm_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4), .DM_WORDS(1024)) dut_a (
        .clk(clk), .rst(rst), .m0(ia0), .m1(ia1), .m0_stall(a_stall),
        .dm_addr(a_dm_addr), .dm_wEn(a_dm_wen), .dm_BusW(a_dm_busw),
        .dm_ByteWidth(a_dm_bw), .dm_SignExt(a_dm_sext), .dm_BusR(a_dm_busr),
        .state_o(a_state)
    );

    dm_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4), .DM_WORDS(1024)) dut_b (
        .clk(clk), .rst(rst), .m0(ib0), .m1(ib1), .m0_stall(b_stall),
        .dm_addr(b_dm_addr), .dm_wEn(b_dm_wen), .dm_BusW(b_dm_busw),
        .dm_ByteWidth(b_dm_bw), .dm_SignExt(b_dm_sext), .dm_BusR(b_dm_busr),
        .state_o(b_state)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] bw, input logic sext);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        b = 8'(w >> (8 * a));
        case (bw)
            2'b11:   return w;
            2'b10:   return sext ? {{16{h[15]}}, h} : {16'h0, h};
            2'b01:   return sext ? {{24{b[7]}}, b} : {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mem_wr(input logic [31:0] old, input logic [1:0] a,
                                           input logic [1:0] bw, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (bw)
            2'b11: r = d;
            2'b10: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            2'b01: case (a)
                2'd0: r[7:0]   = d[7:0];
                2'd1: r[15:8]  = d[7:0];
                2'd2: r[23:16] = d[7:0];
                2'd3: r[31:24] = d[7:0];
            endcase
            default: r = old;
        endcase
        return r;
    endfunction

    always_comb a_dm_busr = mem_rd(mem_a[a_dm_addr[11:2]], a_dm_addr[1:0], a_dm_bw, a_dm_sext);
    always_comb b_dm_busr = mem_rd(mem_b[b_dm_addr[11:2]], b_dm_addr[1:0], b_dm_bw, b_dm_sext);

    // Memory contents and the dm write port
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[4] = 32'hDEADBEEF;
        mem_a[1] = 32'h11223344;
        mem_a[8] = 32'h55667788;
        mem_b[4] = 32'h0B0B0B0B;
        mem_b[1] = 32'h1B1B1B1B;
        forever begin
            @(posedge clk);
            if (a_dm_wen)
                mem_a[a_dm_addr[11:2]] = mem_wr(mem_a[a_dm_addr[11:2]], a_dm_addr[1:0], a_dm_bw, a_dm_busw);
            if (b_dm_wen)
                mem_b[b_dm_addr[11:2]] = mem_wr(mem_b[b_dm_addr[11:2]], b_dm_addr[1:0], b_dm_bw, b_dm_busw);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One m0 access on dut_a with m1 idle: checks stall, ACCESS drive and ack at N+2.
    task automatic m0_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] bw, input logic sext,
                             input logic [31:0] exp_rdata, input logic exp_err);
        ia0.req = 1'b1; ia0.we = we; ia0.addr = addr;
        ia0.wdata = wdata; ia0.bw = bw; ia0.sext = sext;
        @(negedge clk);
        check({tag, "_stall_n"}, 32'(a_stall), 32'd1);
        check({tag, "_ack_n"}, 32'(ia0.ack), 32'd0);
        @(negedge clk);
        check({tag, "_state_acc"}, 32'(a_state), 32'(ST_ACCESS));
        check({tag, "_wen"}, 32'(a_dm_wen), 32'(we & ~exp_err));
        check({tag, "_bw"}, 32'(a_dm_bw), exp_err ? 32'd0 : 32'(bw));
        check({tag, "_ack_n1"}, 32'(ia0.ack), 32'd0);
        @(negedge clk);
        check({tag, "_ack"}, 32'(ia0.ack), 32'd1);
        check({tag, "_err"}, 32'(ia0.err), 32'(exp_err));
        check({tag, "_rdata"}, ia0.rdata, exp_rdata);
        check({tag, "_stall_ack"}, 32'(a_stall), 32'd0);
        @(posedge clk); #1;
        ia0.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last;
        ia0.req = 0; ia0.we = 0; ia0.addr = 0; ia0.wdata = 0; ia0.bw = 0; ia0.sext = 0;
        ia1.req = 0; ia1.we = 0; ia1.addr = 0; ia1.wdata = 0; ia1.bw = 0; ia1.sext = 0;
        ib0.req = 0; ib0.we = 0; ib0.addr = 0; ib0.wdata = 0; ib0.bw = 0; ib0.sext = 0;
        ib1.req = 0; ib1.we = 0; ib1.addr = 0; ib1.wdata = 0; ib1.bw = 0; ib1.sext = 0;

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(a_state), 32'(ST_IDLE));
        check("rst_ack", {30'h0, ia0.ack, ia1.ack}, 32'd0);
        check("rst_err", {30'h0, ia0.err, ia1.err}, 32'd0);
        check("rst_rdata", ia0.rdata | ia1.rdata, 32'd0);
        check("rst_dm_addr", a_dm_addr, 32'd0);
        check("rst_dm_ctl", {27'h0, a_dm_wen, a_dm_bw, a_dm_sext, a_stall}, 32'd0);
        check("rst_dm_busw", a_dm_busw, 32'd0);
        @(posedge clk); #1;

        // Single word load
        m0_access("ld_word", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);

        // Byte store then sign/zero-extended byte loads
        m0_access("st_byte", 1'b1, 32'h13, 32'h000000A5, 2'b01, 1'b0, 32'h0, 1'b0);
        check("st_byte_mem", mem_a[4], 32'hA5ADBEEF);
        m0_access("ld_byte_sx", 1'b0, 32'h13, 32'h0, 2'b01, 1'b1, 32'hFFFFFFA5, 1'b0);
        m0_access("ld_byte_zx", 1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 32'h000000A5, 1'b0);
        m0_access("ld_half_sx", 1'b0, 32'h12, 32'h0, 2'b10, 1'b1, 32'hFFFFA5AD, 1'b0);

        // Faults
        m0_access("f_word_mis", 1'b1, 32'h2, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 1'b1);
        m0_access("f_half_mis", 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        m0_access("f_bw_none", 1'b1, 32'h0, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h0, 1'b1);
        m0_access("f_range", 1'b1, 32'h1000, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 1'b1);
        check("f_mem0", mem_a[0], 32'h0);
        m0_access("st_last", 1'b1, 32'hFFC, 32'h12345678, 2'b11, 1'b0, 32'h0, 1'b0);
        check("st_last_mem", mem_a[1023], 32'h12345678);
        m0_access("ld_last", 1'b0, 32'hFFC, 32'h0, 2'b11, 1'b0, 32'h12345678, 1'b0);

        // Fixed priority with starvation escape: m0 x4, m1, m0
        ia0.we = 0; ia0.addr = 32'h10; ia0.bw = 2'b11; ia0.sext = 0;
        ia1.we = 0; ia1.addr = 32'h4;  ia1.bw = 2'b11; ia1.sext = 0;
        ia0.req = 1'b1; ia1.req = 1'b1;
        n = 0; last = 0;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            @(negedge clk);
            if (ia0.ack || ia1.ack) begin
                check($sformatf("fix_owner%0d", n), 32'(ia1.ack), 32'(n == 4));
                check($sformatf("fix_rdata%0d", n), ia0.rdata | ia1.rdata,
                      (n == 4) ? 32'h11223344 : 32'hA5ADBEEF);
                check($sformatf("fix_stall%0d", n), 32'(a_stall), 32'(n == 4));
                check($sformatf("fix_gap%0d", n), 32'(cyc - last), (n == 0) ? 32'd2 : 32'd3);
                last = cyc;
                n++;
            end
        end
        check("fix_count", 32'(n), 32'd6);
        @(posedge clk); #1;
        ia0.req = 1'b0; ia1.req = 1'b0;

        // Round-robin: alternate m0, m1, m0, m1
        ib0.we = 0; ib0.addr = 32'h10; ib0.bw = 2'b11;
        ib1.we = 0; ib1.addr = 32'h4;  ib1.bw = 2'b11;
        ib0.req = 1'b1; ib1.req = 1'b1;
        n = 0; last = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk);
            if (ib0.ack || ib1.ack) begin
                check($sformatf("rr_owner%0d", n), 32'(ib1.ack), 32'(n % 2));
                check($sformatf("rr_rdata%0d", n), ib0.rdata | ib1.rdata,
                      (n % 2 == 1) ? 32'h1B1B1B1B : 32'h0B0B0B0B);
                check($sformatf("rr_gap%0d", n), 32'(cyc - last), (n == 0) ? 32'd2 : 32'd3);
                last = cyc;
                n++;
            end
        end
        check("rr_count", 32'(n), 32'd4);
        @(posedge clk); #1;
        ib0.req = 1'b0; ib1.req = 1'b0;

        // Reset during ACCESS of a store
        ia0.req = 1'b1; ia0.we = 1'b1; ia0.addr = 32'h20; ia0.wdata = 32'hCAFEF00D; ia0.bw = 2'b11;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; ia0.req = 1'b0;
        @(negedge clk);
        check("rst_acc_state", 32'(a_state), 32'(ST_ACCESS));
        check("rst_acc_wen", 32'(a_dm_wen), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_acc_idle", 32'(a_state), 32'(ST_IDLE));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_acc_noack%0d", k), 32'(ia0.ack), 32'd0);
            @(negedge clk);
        end
        check("rst_acc_mem", mem_a[8], 32'h55667788);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
